// File: rtl/uart_rx_deserializer_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver FSM state encoding, line-level constants, default
// frame parameters and a counter-width helper.
// No ports (package).
package uart_rx_deserializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
// Counts clk_sis cycles 0..CLK_DIV-1 and pulses tick for one cycle at the
// wrap. A synchronous restart forces the count back to 0 so the tick phase
// can be aligned to an external event (e.g. a start-bit edge).
// Ports:
//   clk_sis  in   system clock
//   rst      in   asynchronous active-high reset
//   restart  in   synchronous counter clear
//   tick     out  one-cycle pulse every CLK_DIV cycles
module uart_baud_tick
  import uart_rx_deserializer_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_sis,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == CNT_LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver with one-entry holding register.
// Synchronises rx, oversamples it with uart_baud_tick, recovers frames
// (start low, DATA_BITS data LSB-first, stop high) and presents each byte
// with a valid/ack handshake. Reports framing errors and overruns.
// Ports:
//   clk_sis        in   system clock
//   rst            in   asynchronous active-high reset
//   rx             in   serial line, idle high, asynchronous
//   rx_ack         in   one-cycle pop of the holding register
//   rx_data        out  received byte, stable while rx_valid
//   rx_valid       out  holding register full
//   framing_error  out  one-cycle pulse when the stop bit is sampled low
//   overrun        out  sticky, a frame completed while rx_valid was set
//   busy           out  FSM not idle
module uart_rx_deserializer
  import uart_rx_deserializer_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk_sis,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = cnt_width(OVERSAMPLE);
  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 ferr_q, ferr_d;
  logic                 tick, restart, deliver;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) begin
      rx_meta_q <= LINE_IDLE;
      rx_s_q    <= LINE_IDLE;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Restarting the divider on the start edge puts the sampling phase
  // a fixed distance from the edge regardless of where the divider was.
  assign restart = (state_q == ST_IDLE) && (rx_s_q == START_LEVEL);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .clk_sis (clk_sis),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // FSM: state register
  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (rx_s_q == START_LEVEL) state_d = ST_START;
      ST_START:
        if (tick && tick_cnt_q == HALF_LAST)
          state_d = (rx_s_q == START_LEVEL) ? ST_DATA : ST_IDLE;
      ST_DATA:
        if (tick && tick_cnt_q == TICK_LAST && bit_idx_q == BIT_LAST)
          state_d = ST_STOP;
      ST_STOP:
        if (tick && tick_cnt_q == TICK_LAST)
          state_d = (rx_s_q == STOP_LEVEL) ? ST_IDLE : ST_BREAK;
      ST_BREAK:
        if (rx_s_q == LINE_IDLE) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Counters, shift register and holding register
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    ferr_d     = 1'b0;
    deliver    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
      end
      ST_START:
        if (tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      ST_DATA:
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            shreg_d    = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            bit_idx_d  = bit_idx_q + 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      ST_STOP:
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (rx_s_q == STOP_LEVEL) deliver = 1'b1;
            else                      ferr_d  = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      default: ;
    endcase

    if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    // An ack in the delivery cycle frees the slot for the new byte.
    if (deliver) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sis or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign overrun       = overrun_q;
  assign framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed testbench for uart_rx_deserializer (CLK_DIV=2, OVERSAMPLE=16,
// 32 clk per bit). Stimulus changes 1 ns after a rising edge.
module tb_uart_rx_deserializer;

  logic       clk_sis = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int ferr_cnt = 0;
  int ferr_snap;

  always #5 clk_sis = ~clk_sis;

  uart_rx_deserializer #(
    .CLK_DIV    (2),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk_sis       (clk_sis),
    .rst           (rst),
    .rx            (rx),
    .rx_ack        (rx_ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  // Number of cycles framing_error was high.
  always @(posedge clk_sis) begin
    if (framing_error === 1'b1) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, ending 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_sis);
    #1;
  endtask

  // Start bit plus data bits, 288 clk.
  task automatic drive_head(input logic [7:0] d);
    rx = 1'b0;
    step(32);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(32);
    end
  endtask

  // Full 320-clk frame; optional ack in the cycle of the delivery edge
  // (start edge + 307 clk).
  task automatic frame(input logic [7:0] d, input logic stop_b, input logic ack_at_deliver);
    drive_head(d);
    rx = stop_b;
    step(18);
    if (ack_at_deliver) rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
    step(13);
    rx = 1'b1;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    step(1);
    rx_ack = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    rx     = 1'b1;
    rx_ack = 1'b0;

    // 1. reset and idle line
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_valid", rx_valid, 0);
    rst = 1'b0;
    step(100);
    chk("idle_data", rx_data, 8'h00);
    chk("idle_valid", rx_valid, 0);
    chk("idle_ferr", framing_error, 0);
    chk("idle_ovr", overrun, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ferr_cnt", ferr_cnt, 0);

    // 2. frame 0x5B, exact latency 307 clk
    drive_head(8'h5B);
    chk("f5b_busy_mid", busy, 1);
    rx = 1'b1;
    step(18);
    chk("f5b_valid_early", rx_valid, 0);
    step(1);
    chk("f5b_valid_307", rx_valid, 1);
    chk("f5b_data", rx_data, 8'h5B);
    step(13);
    chk("f5b_busy_end", busy, 0);
    pulse_ack();
    chk("f5b_ack_valid", rx_valid, 0);
    chk("f5b_hold_data", rx_data, 8'h5B);
    step(20);

    // 3. 6-clk glitch rejected
    ferr_snap = ferr_cnt;
    rx = 1'b0;
    step(6);
    rx = 1'b1;
    chk("glitch_busy", busy, 1);
    step(60);
    chk("glitch_idle", busy, 0);
    chk("glitch_valid", rx_valid, 0);
    chk("glitch_ferr", ferr_cnt - ferr_snap, 0);

    // 4. bad stop, line held low, then good frame
    ferr_snap = ferr_cnt;
    drive_head(8'h42);
    rx = 1'b0;
    step(32 + 64);
    chk("brk_busy", busy, 1);
    rx = 1'b1;
    step(40);
    chk("brk_ferr_once", ferr_cnt - ferr_snap, 1);
    chk("brk_valid", rx_valid, 0);
    chk("brk_idle", busy, 0);
    frame(8'hA5, 1'b1, 1'b0);
    chk("fa5_valid", rx_valid, 1);
    chk("fa5_data", rx_data, 8'hA5);
    pulse_ack();
    chk("fa5_ack", rx_valid, 0);
    step(20);

    // 5. overrun and ack coincident with delivery
    frame(8'h11, 1'b1, 1'b0);
    chk("o11_data", rx_data, 8'h11);
    chk("o11_ovr", overrun, 0);
    frame(8'h22, 1'b1, 1'b0);
    chk("o22_keep", rx_data, 8'h11);
    chk("o22_valid", rx_valid, 1);
    chk("o22_ovr", overrun, 1);
    pulse_ack();
    chk("oack_valid", rx_valid, 0);
    chk("oack_ovr", overrun, 0);
    frame(8'h11, 1'b1, 1'b0);
    frame(8'h33, 1'b1, 1'b0);
    chk("o33_ovr", overrun, 1);
    chk("o33_keep", rx_data, 8'h11);
    frame(8'h22, 1'b1, 1'b1);
    chk("coin_data", rx_data, 8'h22);
    chk("coin_valid", rx_valid, 1);
    chk("coin_ovr", overrun, 0);
    step(10);

    // 6. reset during data bit 4 of 0xFF
    rx = 1'b0;
    step(32);
    rx = 1'b1;
    step(128 + 16);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #2;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_ovr", overrun, 0);
    step(3);
    rst = 1'b0;
    step(150);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", rx_valid, 0);
    frame(8'h3C, 1'b1, 1'b0);
    chk("f3c_valid", rx_valid, 1);
    chk("f3c_data", rx_data, 8'h3C);
    chk("total_ferr", ferr_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
